axi_burst_mem_slave: RTL
========================

AXI_BURST_MEM_SLAVE -- requirements
Module: axi_burst_mem_slave

Interface
REQ-001 DATA_WIDTH, default 8, width of AXI data and memory word; one word per beat.
REQ-002 ADDR_WIDTH, default 10, width of AXI and memory addresses, in words.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 s_awaddr  input  ADDR_WIDTH  write burst start address.
REQ-006 s_awlen  input  8  write beats minus one.
REQ-007 s_awvalid  input  1  write address valid.
REQ-008 s_awready  output  1  write address ready.
REQ-009 s_wdata  input  DATA_WIDTH  write beat data.
REQ-010 s_wlast  input  1  final write beat marker.
REQ-011 s_wvalid  input  1  write data valid.
REQ-012 s_wready  output  1  write data ready.
REQ-013 s_bresp  output  2  write response: 00 is OKAY, 10 is SLVERR.
REQ-014 s_bvalid  output  1  write response valid.
REQ-015 s_bready  input  1  write response ready.
REQ-016 s_araddr  input  ADDR_WIDTH  read burst start address.
REQ-017 s_arlen  input  8  read beats minus one.
REQ-018 s_arvalid  input  1  read address valid.
REQ-019 s_arready  output  1  read address ready.
REQ-020 s_rdata  output  DATA_WIDTH  read beat data.
REQ-021 s_rresp  output  2  read response; always 00.
REQ-022 s_rlast  output  1  final read beat marker.
REQ-023 s_rvalid  output  1  read data valid.
REQ-024 s_rready  input  1  read data ready.
REQ-025 mem_write_en  output  1  memory write strobe.
REQ-026 mem_write_address  output  ADDR_WIDTH  memory write address.
REQ-027 mem_data_in  output  DATA_WIDTH  memory write data.
REQ-028 mem_read_en  output  1  memory read strobe; the memory registers data one cycle later.
REQ-029 mem_read_address  output  ADDR_WIDTH  memory read address.
REQ-030 mem_data_out  input  DATA_WIDTH  registered memory read data; holds its value while mem_read_en is 0.

Function
REQ-031 Write FSM in W_IDLE: s_awready=1. On AW handshake, latch the address and length, then go to W_DATA.
REQ-032 Write FSM in W_DATA: s_wready=1. On each W handshake, in the same cycle: mem_write_en=1, mem_write_address=current address, mem_data_in=s_wdata. Then address+1 and beat count+1.
REQ-033 After handshake of beat awlen+1, go to W_RESP. s_bvalid=1 from the next cycle until s_bready, then go to W_IDLE. One write burst outstanding at a time.
REQ-034 s_bresp=10 if s_wlast was 1 on a non-final beat or 0 on the final beat; otherwise 00. Beat counting is by awlen only.
REQ-035 Read FSM in R_IDLE: s_arready=1. On AR handshake, latch the address and length, then go to R_FETCH. R_FETCH: mem_read_en=1 at the start address for one cycle, then go to R_SEND.
REQ-036 Read FSM in R_SEND: s_rvalid=1, s_rdata=mem_data_out, s_rlast=1 on beat arlen+1.
REQ-037 On a non-final R handshake, assert mem_read_en at the next address in that cycle and stay in R_SEND, so the bus sustains one beat per cycle. On the final R handshake, go to R_IDLE.
REQ-038 While s_rready=0 in R_SEND: mem_read_en=0, and s_rdata and s_rlast are held stable.
REQ-039 Latency: first s_rvalid in the second cycle after the AR handshake. A write reaches memory in the cycle of its W handshake.
REQ-040 Addresses wrap from 2^ADDR_WIDTH-1 to 0. awlen=0 or arlen=0 is a single beat. A length of 255 is 256 beats.
REQ-041 Read and write paths are fully independent. A same-cycle write and read to one address returns the pre-write data.
REQ-042 mem_write_en is 1 only on a W_DATA handshake. mem_read_en is 1 only in R_FETCH or on a non-final R_SEND handshake.

Reset
REQ-043 While rst_n=0, asynchronously: both FSMs go to IDLE, counters and latches clear, and every output is 0, including ready signals.
REQ-044 In-flight bursts are dropped with no B or R response. s_awready and s_arready go to 1 in the first cycle after rst_n rises.

Structure
REQ-045 Package axi_burst_pkg holds: write and read state encodings, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and LEN_WIDTH=8.
REQ-046 Sub-module axi_burst_beat_ctr (load, increment, wrapping address, last-beat flag) is instantiated twice, once per path.

Verification
REQ-047 AW addr=0x3FE, len=3, data A0..A3, wlast on beat 4 -> writes to 0x3FE, 0x3FF, 0x000, 0x001; bresp=00.
REQ-048 AR addr=0x3FE, len=3, rready=1 -> rvalid 2 cycles after AR; A0..A3 on 4 consecutive cycles; rlast on A3.
REQ-049 Same read with rready toggled 1,0,0,1 -> no duplicate or skipped beat; rdata held during stalls.
REQ-050 Write len=1 with wlast on beat 1 -> 2 memory writes, bresp=10.
REQ-051 Assert rst_n=0 mid-read, at beat 2 of 4 -> rvalid=0 immediately; after release arready=1 and a new burst completes normally.

Source files
------------

// File: rtl/axi_burst_pkg.sv
// Shared encodings and constants for the AXI burst memory slave.
package axi_burst_pkg;

    localparam int LEN_WIDTH = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_SEND  = 2'd2
    } r_state_t;

endpackage

// File: rtl/axi_burst_beat_ctr.sv
// Burst beat tracker: loads start address and length, steps a wrapping
// address per beat and flags the final beat of the burst.
module axi_burst_beat_ctr
    import axi_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH-1:0] o_addr_next,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [LEN_WIDTH-1:0]  r_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_cnt  <= '0;
            r_len  <= i_len;
        end else if (i_inc) begin
            r_addr <= r_addr + ADDR_ONE;
            r_cnt  <= r_cnt + CNT_ONE;
        end
    end

    // Address arithmetic is modulo 2^ADDR_WIDTH, so bursts wrap naturally.
    assign o_addr      = r_addr;
    assign o_addr_next = r_addr + ADDR_ONE;
    assign o_last      = (r_cnt == r_len);

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI-style burst slave in front of a registered-read memory; independent
// write (AW/W/B) and read (AR/R) state machines.
module axi_burst_mem_slave
    import axi_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [LEN_WIDTH-1:0]  s_awlen,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [LEN_WIDTH-1:0]  s_arlen,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    w_state_t r_w_state, w_w_state_next;
    r_state_t r_r_state, w_r_state_next;
    logic     r_rst_done;
    logic     r_w_err;

    logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [ADDR_WIDTH-1:0] w_wr_addr, w_wr_addr_next, w_rd_addr, w_rd_addr_next;
    logic                  w_wr_last, w_rd_last;

    assign w_aw_hs = s_awvalid & s_awready;
    assign w_w_hs  = s_wvalid  & s_wready;
    assign w_b_hs  = s_bvalid  & s_bready;
    assign w_ar_hs = s_arvalid & s_arready;
    assign w_r_hs  = s_rvalid  & s_rready;

    // Holds the address-ready outputs low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_done <= 1'b0;
        else        r_rst_done <= 1'b1;
    end

    axi_burst_beat_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ctr (
        .clk(clk), .rst_n(rst_n), .i_load(w_aw_hs), .i_addr(s_awaddr), .i_len(s_awlen),
        .i_inc(w_w_hs), .o_addr(w_wr_addr), .o_addr_next(w_wr_addr_next), .o_last(w_wr_last)
    );

    axi_burst_beat_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ctr (
        .clk(clk), .rst_n(rst_n), .i_load(w_ar_hs), .i_addr(s_araddr), .i_len(s_arlen),
        .i_inc(w_r_hs), .o_addr(w_rd_addr), .o_addr_next(w_rd_addr_next), .o_last(w_rd_last)
    );

    // Sticky protocol error: wlast disagreeing with the awlen-derived final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_w_err <= 1'b0;
        else if (w_aw_hs)                        r_w_err <= 1'b0;
        else if (w_w_hs && (s_wlast != w_wr_last)) r_w_err <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_w_state <= W_IDLE;
        else        r_w_state <= w_w_state_next;
    end

    always_comb begin
        w_w_state_next = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs)              w_w_state_next = W_DATA;
            W_DATA:  if (w_w_hs && w_wr_last)  w_w_state_next = W_RESP;
            W_RESP:  if (w_b_hs)               w_w_state_next = W_IDLE;
            default:                           w_w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_awready         = r_rst_done && (r_w_state == W_IDLE);
        s_wready          = (r_w_state == W_DATA);
        s_bvalid          = (r_w_state == W_RESP);
        s_bresp           = (s_bvalid && r_w_err) ? RESP_SLVERR : RESP_OKAY;
        mem_write_en      = w_w_hs;
        mem_write_address = w_w_hs ? w_wr_addr : '0;
        mem_data_in       = w_w_hs ? s_wdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_r_state <= R_IDLE;
        else        r_r_state <= w_r_state_next;
    end

    always_comb begin
        w_r_state_next = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs)              w_r_state_next = R_FETCH;
            R_FETCH:                           w_r_state_next = R_SEND;
            R_SEND:  if (w_r_hs && w_rd_last)  w_r_state_next = R_IDLE;
            default:                           w_r_state_next = R_IDLE;
        endcase
    end

    // Prefetching the next beat on each accepted beat sustains one beat per cycle;
    // during a stall the memory output is left untouched and so holds s_rdata.
    always_comb begin
        s_arready        = r_rst_done && (r_r_state == R_IDLE);
        s_rvalid         = (r_r_state == R_SEND);
        s_rlast          = s_rvalid && w_rd_last;
        s_rdata          = s_rvalid ? mem_data_out : '0;
        s_rresp          = RESP_OKAY;
        mem_read_en      = 1'b0;
        mem_read_address = '0;
        if (r_r_state == R_FETCH) begin
            mem_read_en      = 1'b1;
            mem_read_address = w_rd_addr;
        end else if (w_r_hs && !w_rd_last) begin
            mem_read_en      = 1'b1;
            mem_read_address = w_rd_addr_next;
        end
    end

endmodule
